mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Arbiter and request formatter that sits directly upstream of the byte-serial memory controller. It accepts requests from the instruction-fetch port and the load/store port, and selects one. It issues that request as a single-cycle bus transaction and waits for the controller's response pulse. It then returns size-masked, optionally sign-extended read data to the requester. It guarantees one outstanding transaction and never presents a size code the controller cannot complete.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: width of all address ports.

Ports:
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_if_req`  in  1  fetch request; level, held until `o_if_ack`.
- `i_if_address`  in  ADDR_WIDTH  fetch address; always a 4-byte read.
- `o_if_data`  out  32  fetched word; valid with `o_if_ack`.
- `o_if_ack`  out  1  one-cycle completion pulse, fetch port.
- `i_ls_req`  in  1  load/store request; level, held until `o_ls_ack`.
- `i_ls_write`  in  1  1 = store, 0 = load.
- `i_ls_address`  in  ADDR_WIDTH  load/store address.
- `i_ls_data`  in  32  store data, little-endian from bit 0.
- `i_ls_bhw`  in  3  byte count: 1, 2 or 4.
- `i_ls_unsigned`  in  1  1 = zero-extend loads, 0 = sign-extend.
- `o_ls_data`  out  32  load result; 0 for stores and errors.
- `o_ls_ack`  out  1  one-cycle completion pulse, load/store port.
- `o_ls_err`  out  1  with `o_ls_ack`: request rejected (illegal `i_ls_bhw`).
- `o_bus_data`, `o_bus_address`  out  32, ADDR_WIDTH  to controller.
- `o_bhw`  out  3  to controller, byte count.
- `o_write_notread`  out  1  to controller.
- `o_bus_DV`  out  1  one-cycle request strobe to controller.
- `i_bus_data`  in  32  controller response data.
- `i_bus_DV`  in  1  controller response pulse.
- `o_busy`  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any request is pending, latch the winner's fields into registers, record the grantee, and go to ISSUE.
  - The address, data, bhw, write and unsigned fields are latched; the fetch port latches bhw=4, write=0, data=0.
  - A load/store request with `i_ls_bhw` ∉ {1,2,4} is granted but goes straight to RESP with err=1. It never reaches the bus.
- ISSUE: drive `o_bus_DV`=1 for exactly this cycle with the latched fields, then go to WAIT.
- WAIT:
  - Hold the bus fields stable.
  - When `i_bus_DV`=1, latch the formatted data and go to RESP.
- RESP:
  - Pulse the grantee's ack for one cycle with the data and, for the load/store port, err. Then go to IDLE.
  - Requesters deassert or change the request after ack. A still-high request in the next IDLE cycle is a new request.
- Read formatting (loads only):
  - bhw=1: bits [7:0], extended from bit 7.
  - bhw=2: bits [15:0], extended from bit 15.
  - bhw=4: all 32 bits.
  - Extension is zero if unsigned=1, otherwise sign.
  - Upper bytes returned by the controller are always discarded for 1- and 2-byte loads.
- Stores: return `o_ls_data`=0; the ack is still issued on the response.
- Priority with both requests in the same IDLE cycle: the load/store port wins (fixed). See Configuration.
- `i_bus_DV` outside WAIT is ignored.
- `o_bhw`=0 or any value other than 1, 2, 4 is never driven while `o_bus_DV`=1.
- Unselected-port outputs hold 0; `o_if_data`/`o_ls_data` are 0 except during their ack cycle.

## Timing
- Reset: state=IDLE; all outputs 0 (`o_bus_*`, `o_bhw`, `o_write_notread`, acks, err, data, `o_busy`).
- A request seen in IDLE at cycle 0 gives `o_bus_DV` at cycle 1.
- A response `i_bus_DV` at cycle N gives the ack at cycle N+1.
- The next `o_bus_DV` is at N+3 at the earliest. The controller re-accepts one cycle after its response, so this is always legal.
- An illegal-bhw request at cycle 0 gives an ack with err at cycle 1; no bus activity.
- Reset mid-WAIT returns to IDLE; a later stray `i_bus_DV` is ignored. Reset of the controller is a system concern.
- A request dropped before ack is unsupported; the transaction completes and the ack is still pulsed.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - On simultaneous requests, the port not granted last wins.
  - The last-grantee register resets to fetch, so the first tie goes to load/store.
- Undefined: fixed priority, load/store always wins ties. Fetch can starve under continuous load/store traffic.

## Test plan
- Fetch at 0x100, controller returns 0xDEADBEEF after 6 cycles → `o_bus_DV` one cycle with bhw=4, write=0; `o_if_ack` with 0xDEADBEEF one cycle after the response.
- Signed byte load, controller returns 0x123456F0 → `o_ls_data`=0xFFFFFFF0. Same with unsigned=1 → 0x000000F0.
- Half load, unsigned=0, response 0xAAAA8001 → 0xFFFF8001. Store 0x11223344 bhw=4 at 0x20 → bus data 0x11223344, write=1; ack with data 0.
- `i_ls_bhw`=0 and =3 → `o_ls_ack` + `o_ls_err` next cycle, `o_bus_DV` never asserted.
- Both ports request continuously for 4 transactions → fixed priority: all load/store. With `MEM_ARB_RR_EN`: LS, IF, LS, IF.
- Reset asserted during WAIT, then `i_bus_DV` pulse → no ack; outputs 0; the next request issues normally.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the fetch port, load/store port and controller bus signals
// handled by mem_bus_arbiter.
// slave  : the arbiter's view (drives acks, read data and the bus request).
// master : the environment's view (drives requests and the controller response).
`timescale 1ns/1ps

interface mem_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  // Instruction-fetch port
  logic                  i_if_req;
  logic [ADDR_WIDTH-1:0] i_if_address;
  logic [31:0]           o_if_data;
  logic                  o_if_ack;

  // Load/store port
  logic                  i_ls_req;
  logic                  i_ls_write;
  logic [ADDR_WIDTH-1:0] i_ls_address;
  logic [31:0]           i_ls_data;
  logic [2:0]            i_ls_bhw;
  logic                  i_ls_unsigned;
  logic [31:0]           o_ls_data;
  logic                  o_ls_ack;
  logic                  o_ls_err;

  // Memory controller side
  logic [31:0]           o_bus_data;
  logic [ADDR_WIDTH-1:0] o_bus_address;
  logic [2:0]            o_bhw;
  logic                  o_write_notread;
  logic                  o_bus_DV;
  logic [31:0]           i_bus_data;
  logic                  i_bus_DV;
  logic                  o_busy;

  modport slave (
    input  i_if_req, i_if_address,
    input  i_ls_req, i_ls_write, i_ls_address, i_ls_data, i_ls_bhw, i_ls_unsigned,
    input  i_bus_data, i_bus_DV,
    output o_if_data, o_if_ack,
    output o_ls_data, o_ls_ack, o_ls_err,
    output o_bus_data, o_bus_address, o_bhw, o_write_notread, o_bus_DV, o_busy
  );

  modport master (
    output i_if_req, i_if_address,
    output i_ls_req, i_ls_write, i_ls_address, i_ls_data, i_ls_bhw, i_ls_unsigned,
    output i_bus_data, i_bus_DV,
    input  o_if_data, o_if_ack,
    input  o_ls_data, o_ls_ack, o_ls_err,
    input  o_bus_data, o_bus_address, o_bhw, o_write_notread, o_bus_DV, o_busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter and request formatter in front of the byte-serial memory
// controller. One transaction outstanding at a time; loads are size-masked
// and sign/zero-extended before being returned to the requester.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration on
// simultaneous requests; otherwise the load/store port always wins ties.
`timescale 1ns/1ps

module mem_bus_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  mem_bus_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic                  grant_ls_q, grant_ls_d;
  logic                  unsigned_q, unsigned_d;
  logic                  bus_dv_q, bus_dv_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [31:0]           bus_data_q, bus_data_d;
  logic [2:0]            bhw_q, bhw_d;
  logic                  write_q, write_d;
  logic                  if_ack_q, if_ack_d;
  logic [31:0]           if_data_q, if_data_d;
  logic                  ls_ack_q, ls_ack_d;
  logic                  ls_err_q, ls_err_d;
  logic [31:0]           ls_data_q, ls_data_d;
  logic                  busy_q, busy_d;
`ifdef MEM_ARB_RR_EN
  logic                  last_ls_q, last_ls_d;
`endif

  logic                  pick_ls;
  logic                  bhw_legal;
  logic                  sign_ext;
  logic [31:0]           load_fmt;

  // Winner selection and read-data formatting
  always_comb begin
`ifdef MEM_ARB_RR_EN
    // On a tie, the port that was not granted last wins.
    pick_ls = bus.i_ls_req && (!bus.i_if_req || !last_ls_q);
`else
    pick_ls = bus.i_ls_req;
`endif
    bhw_legal = (bus.i_ls_bhw == 3'd1) || (bus.i_ls_bhw == 3'd2) || (bus.i_ls_bhw == 3'd4);
    sign_ext  = ~unsigned_q;
    // Upper bytes from the controller are dropped for narrow loads.
    case (bhw_q)
      3'd1:    load_fmt = {{24{sign_ext & bus.i_bus_data[7]}},  bus.i_bus_data[7:0]};
      3'd2:    load_fmt = {{16{sign_ext & bus.i_bus_data[15]}}, bus.i_bus_data[15:0]};
      default: load_fmt = bus.i_bus_data;
    endcase
  end

  // Next-state and next-output computation for the transaction FSM
  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    grant_ls_d = grant_ls_q;
    unsigned_d = unsigned_q;
    bus_addr_d = bus_addr_q;
    bus_data_d = bus_data_q;
    bhw_d      = bhw_q;
    write_d    = write_q;
`ifdef MEM_ARB_RR_EN
    last_ls_d  = last_ls_q;
`endif
    // Pulses and response data are zero unless set below.
    bus_dv_d   = 1'b0;
    if_ack_d   = 1'b0;
    if_data_d  = 32'd0;
    ls_ack_d   = 1'b0;
    ls_err_d   = 1'b0;
    ls_data_d  = 32'd0;

    case (state_q)
      IDLE: begin
        if (bus.i_if_req || bus.i_ls_req) begin
          grant_ls_d = pick_ls;
`ifdef MEM_ARB_RR_EN
          last_ls_d  = pick_ls;
`endif
          if (pick_ls && !bhw_legal) begin
            // Rejected without touching the bus.
            ls_ack_d = 1'b1;
            ls_err_d = 1'b1;
            state_d  = RESP;
          end else if (pick_ls) begin
            bus_addr_d = bus.i_ls_address;
            bus_data_d = bus.i_ls_data;
            bhw_d      = bus.i_ls_bhw;
            write_d    = bus.i_ls_write;
            unsigned_d = bus.i_ls_unsigned;
            bus_dv_d   = 1'b1;
            state_d    = ISSUE;
          end else begin
            bus_addr_d = bus.i_if_address;
            bus_data_d = 32'd0;
            bhw_d      = 3'd4;
            write_d    = 1'b0;
            unsigned_d = 1'b1;
            bus_dv_d   = 1'b1;
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.i_bus_DV) begin
          if (grant_ls_q) begin
            ls_ack_d  = 1'b1;
            ls_data_d = write_q ? 32'd0 : load_fmt;
          end else begin
            if_ack_d  = 1'b1;
            if_data_d = bus.i_bus_data;
          end
          bus_addr_d = '0;
          bus_data_d = 32'd0;
          bhw_d      = 3'd0;
          write_d    = 1'b0;
          state_d    = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; synchronous reset clears everything
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (i_rst) begin
      state_q    <= IDLE;
      grant_ls_q <= 1'b0;
      unsigned_q <= 1'b0;
      bus_dv_q   <= 1'b0;
      bus_addr_q <= '0;
      bus_data_q <= 32'd0;
      bhw_q      <= 3'd0;
      write_q    <= 1'b0;
      if_ack_q   <= 1'b0;
      if_data_q  <= 32'd0;
      ls_ack_q   <= 1'b0;
      ls_err_q   <= 1'b0;
      ls_data_q  <= 32'd0;
      busy_q     <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_ls_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_ls_q <= grant_ls_d;
      unsigned_q <= unsigned_d;
      bus_dv_q   <= bus_dv_d;
      bus_addr_q <= bus_addr_d;
      bus_data_q <= bus_data_d;
      bhw_q      <= bhw_d;
      write_q    <= write_d;
      if_ack_q   <= if_ack_d;
      if_data_q  <= if_data_d;
      ls_ack_q   <= ls_ack_d;
      ls_err_q   <= ls_err_d;
      ls_data_q  <= ls_data_d;
      busy_q     <= busy_d;
`ifdef MEM_ARB_RR_EN
      last_ls_q  <= last_ls_d;
`endif
    end
  end

  assign bus.o_bus_DV        = bus_dv_q;
  assign bus.o_bus_address   = bus_addr_q;
  assign bus.o_bus_data      = bus_data_q;
  assign bus.o_bhw           = bhw_q;
  assign bus.o_write_notread = write_q;
  assign bus.o_if_ack        = if_ack_q;
  assign bus.o_if_data       = if_data_q;
  assign bus.o_ls_ack        = ls_ack_q;
  assign bus.o_ls_err        = ls_err_q;
  assign bus.o_ls_data       = ls_data_q;
  assign bus.o_busy          = busy_q;

endmodule
